rv_onehot_dispatcher: RTL and testbench
=======================================

RV_ONEHOT_DISPATCHER -- requirements
Module: RV_onehot_dispatcher

Interface
REQ-001 SHALL have parameter N, default 8: number of destination lanes, N >= 2.
REQ-002 SHALL have parameter REVERSE, default 0: when 1, index i drives lane N-1-i.
REQ-003 SHALL have parameter DATAW, default 32: payload width.
REQ-004 SHALL have parameter LN, default (N > 1 ? $clog2(N) : 1): index width.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  upstream request valid.
REQ-008 SHALL have port in_index  input  LN  encoded destination lane.
REQ-009 SHALL have port in_data  input  DATAW  payload.
REQ-010 SHALL have port in_ready  output  1  upstream accept; a transfer occurs when in_valid & in_ready.
REQ-011 SHALL have port out_valid  output  N  one-hot lane request; all-zero when idle.
REQ-012 SHALL have port out_data  output  DATAW  payload of the current request.
REQ-013 SHALL have port out_ready  input  N  per-lane accept.
REQ-014 SHALL have port err  output  1  one-cycle pulse on a discarded out-of-range index.
REQ-015 SHALL have port busy  output  1  high when any entry is held.

Function
REQ-016 SHALL hold at most two entries: an output register (OUT) and a skid register (SKID).
REQ-017 SHALL implement states EMPTY (no entries), FULL (OUT only) and SKID (OUT and SKID).
REQ-018 SHALL drive in_ready = 1 in EMPTY and FULL and 0 in SKID, decoded from registered state only, with no combinational path from out_ready.
REQ-019 SHALL, on accept in EMPTY, load OUT and go to FULL, so out_valid asserts one cycle after acceptance.
REQ-020 SHALL complete the output transfer when out_valid[k] & out_ready[k] for the selected lane k; out_ready of unselected lanes SHALL be ignored.
REQ-021 SHALL, in FULL with output transfer and no accept, go to EMPTY.
REQ-022 SHALL, in FULL with simultaneous output transfer and accept, load OUT from the input and stay FULL.
REQ-023 SHALL, in FULL with accept and no output transfer, load SKID and go to SKID.
REQ-024 SHALL, in SKID with output transfer, move SKID into OUT and go to FULL.
REQ-025 SHALL hold out_valid and out_data stable while the selected lane stalls.
REQ-026 SHALL, when in_index >= N (N not a power of 2), accept and discard the request, leave state unchanged, and pulse err for one cycle on the following cycle.
REQ-027 SHALL keep out_valid exactly one-hot or zero in every cycle.
REQ-028 SHALL drive busy = (state != EMPTY).

Reset
REQ-029 SHALL, on reset assertion, immediately force state to EMPTY, out_valid = 0, err = 0 and busy = 0.
REQ-030 SHALL drive in_ready = 0 while reset is asserted and 1 from the first clock edge after deassertion.
REQ-031 SHALL reset out_data to 0 and discard any in-flight OUT and SKID contents when reset is asserted mid-transfer.

Structure
REQ-032 SHALL take the state encodings (EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2) from the shared define header.
REQ-033 SHALL decode index to one-hot, including the REVERSE mapping and range check, in one combinational sub-module named RV_onehot_decoder.
REQ-034 SHALL register the decoded one-hot value with each entry, not re-decode it at the output.

Verification
REQ-035 SHALL be tested with: N=8; in_index=5, data=0xA5 accepted; out_ready=all-1 -> next cycle out_valid=8'b0010_0000, out_data=0xA5; state returns to EMPTY.
REQ-036 SHALL be tested with: REVERSE=1, N=8, in_index=1 -> out_valid=8'b0100_0000.
REQ-037 SHALL be tested with: out_ready=0; three back-to-back requests (idx 0,1,2) -> first two accepted, in_ready=0 on the third; releasing lane 0 -> out_valid=8'b0000_0010 next cycle, in_ready=1, third accepted.
REQ-038 SHALL be tested with: N=6, in_index=7 -> accepted, err pulses one cycle, out_valid stays 0.
REQ-039 SHALL be tested with: streaming in FULL with out_ready[k]=1 every cycle -> one transfer per cycle, no bubbles, in_ready held at 1.
REQ-040 SHALL be tested with: reset asserted in SKID with out_ready=0 -> out_valid=0 and busy=0 without a clock edge; after release, no stale output appears.

Source files
------------

// File: rtl/rv_onehot_dispatcher_pkg.sv
// Shared definitions for the one-hot lane dispatcher.
// Holds the buffer state encodings used by the dispatcher FSM.
package rv_onehot_dispatcher_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } disp_state_e;

endpackage

// File: rtl/rv_onehot_decoder.sv
// Index to one-hot lane decoder with optional reversed lane order.
// Flags indices at or above N so the dispatcher can discard them.
module rv_onehot_decoder #(
    parameter int N       = 8,
    parameter int REVERSE = 0,
    parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
    input  logic [LN-1:0] index,
    output logic [N-1:0]  onehot,
    output logic          in_range
);

    // Decode the index; out-of-range values produce an all-zero vector.
    always_comb begin
        onehot   = '0;
        in_range = (int'(index) < N);
        for (int i = 0; i < N; i++) begin
            if (int'(index) == i) begin
                onehot[(REVERSE != 0) ? (N - 1 - i) : i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv_onehot_dispatcher.sv
// Two-entry skid-buffered dispatcher driving one of N lanes per request.
// in_ready comes only from registered state to cut out_ready timing paths.
module rv_onehot_dispatcher
    import rv_onehot_dispatcher_pkg::*;
#(
    parameter int N       = 8,
    parameter int REVERSE = 0,
    parameter int DATAW   = 32,
    parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [LN-1:0]    in_index,
    input  logic [DATAW-1:0] in_data,
    output logic             in_ready,
    output logic [N-1:0]     out_valid,
    output logic [DATAW-1:0] out_data,
    input  logic [N-1:0]     out_ready,
    output logic             err,
    output logic             busy
);

    disp_state_e      state_q;
    disp_state_e      state_d;
    logic             rdy_q;
    logic             err_q;
    logic [N-1:0]     out_oh_q;
    logic [N-1:0]     skid_oh_q;
    logic [DATAW-1:0] out_data_q;
    logic [DATAW-1:0] skid_data_q;
    logic [N-1:0]     dec_oh;
    logic             in_range;
    logic             accept;
    logic             load;
    logic             fire;
    logic             load_out;
    logic             load_skid;
    logic             move_skid;

    rv_onehot_decoder #(
        .N       (N),
        .REVERSE (REVERSE),
        .LN      (LN)
    ) u_dec (
        .index    (in_index),
        .onehot   (dec_oh),
        .in_range (in_range)
    );

    assign in_ready  = rdy_q & (state_q != ST_SKID);
    assign accept    = in_valid & in_ready;
    assign load      = accept & in_range;
    assign busy      = (state_q != ST_EMPTY);
    assign out_valid = busy ? out_oh_q : '0;
    assign out_data  = out_data_q;
    assign fire      = |(out_valid & out_ready);
    assign err       = err_q;

    // State register, post-reset ready enable and error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            err_q   <= accept & ~in_range;
        end
    end

    // Next state and entry load controls.
    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    load_out = 1'b1;
                    state_d  = ST_FULL;
                end
            end
            ST_FULL: begin
                if (fire && load) begin
                    load_out = 1'b1;
                end else if (fire) begin
                    state_d = ST_EMPTY;
                end else if (load) begin
                    load_skid = 1'b1;
                    state_d   = ST_SKID;
                end
            end
            ST_SKID: begin
                if (fire) begin
                    move_skid = 1'b1;
                    state_d   = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Entry storage; the decoded lane travels with its payload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_oh_q    <= '0;
            out_data_q  <= '0;
            skid_oh_q   <= '0;
            skid_data_q <= '0;
        end else begin
            if (load_out) begin
                out_oh_q   <= dec_oh;
                out_data_q <= in_data;
            end else if (move_skid) begin
                out_oh_q   <= skid_oh_q;
                out_data_q <= skid_data_q;
            end
            if (load_skid) begin
                skid_oh_q   <= dec_oh;
                skid_data_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_rv_onehot_dispatcher.sv
// Directed bench for the one-hot dispatcher.
// Covers default, reversed and non-power-of-two lane counts.
module tb_rv_onehot_dispatcher;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic [2:0]  in_index;
    logic [31:0] in_data;
    logic        in_ready;
    logic [7:0]  out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_ready;
    logic        err;
    logic        busy;

    logic        r_valid;
    logic [2:0]  r_index;
    logic [31:0] r_data;
    logic        r_ready;
    logic [7:0]  r_out_valid;
    logic [31:0] r_out_data;
    logic [7:0]  r_out_ready;
    logic        r_err;
    logic        r_busy;

    logic        s_valid;
    logic [2:0]  s_index;
    logic [31:0] s_data;
    logic        s_ready;
    logic [5:0]  s_out_valid;
    logic [31:0] s_out_data;
    logic [5:0]  s_out_ready;
    logic        s_err;
    logic        s_busy;

    int n_pass;
    int n_total;

    rv_onehot_dispatcher #(.N(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_index  (in_index),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .err       (err),
        .busy      (busy)
    );

    rv_onehot_dispatcher #(.N(8), .REVERSE(1)) u_rev (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_valid),
        .in_index  (r_index),
        .in_data   (r_data),
        .in_ready  (r_ready),
        .out_valid (r_out_valid),
        .out_data  (r_out_data),
        .out_ready (r_out_ready),
        .err       (r_err),
        .busy      (r_busy)
    );

    rv_onehot_dispatcher #(.N(6)) u_n6 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_valid),
        .in_index  (s_index),
        .in_data   (s_data),
        .in_ready  (s_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready),
        .err       (s_err),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_pass   = 0;
        n_total  = 0;
        reset    = 1'b0;
        in_valid = 1'b0; in_index = '0; in_data = '0; out_ready = '0;
        r_valid  = 1'b0; r_index  = '0; r_data  = '0; r_out_ready = '0;
        s_valid  = 1'b0; s_index  = '0; s_data  = '0; s_out_ready = '0;

        #2;
        check("rst_valid", out_valid, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_data", out_data, 32'h0);
        step();
        check("rst_ready_hold", in_ready, 1'b0);
        #2 reset = 1'b1;
        step();
        check("ready_after_rst", in_ready, 1'b1);

        // single request, lane 5
        in_valid = 1'b1; in_index = 3'd5; in_data = 32'hA5; out_ready = 8'hFF;
        step();
        in_valid = 1'b0;
        check("single_valid", out_valid, 8'b0010_0000);
        check("single_data", out_data, 32'hA5);
        check("single_busy", busy, 1'b1);
        step();
        check("single_empty_valid", out_valid, 8'h00);
        check("single_empty_busy", busy, 1'b0);

        // back-to-back with stalled lanes
        out_ready = 8'h00;
        in_valid = 1'b1; in_index = 3'd0; in_data = 32'h10;
        step();
        check("b2b_ready1", in_ready, 1'b1);
        in_index = 3'd1; in_data = 32'h11;
        step();
        check("b2b_ready2", in_ready, 1'b0);
        check("b2b_valid2", out_valid, 8'b0000_0001);
        in_index = 3'd2; in_data = 32'h12;
        out_ready = 8'hFE;
        step();
        check("stall_valid", out_valid, 8'b0000_0001);
        check("stall_data", out_data, 32'h10);
        check("stall_ready", in_ready, 1'b0);
        out_ready = 8'h01;
        step();
        check("release_valid", out_valid, 8'b0000_0010);
        check("release_data", out_data, 32'h11);
        check("release_ready", in_ready, 1'b1);
        out_ready = 8'h00;
        step();
        in_valid = 1'b0;
        check("third_acc_ready", in_ready, 1'b0);
        check("third_acc_valid", out_valid, 8'b0000_0010);
        out_ready = 8'hFF;
        step();
        check("third_valid", out_valid, 8'b0000_0100);
        check("third_data", out_data, 32'h12);
        step();
        check("b2b_drain_busy", busy, 1'b0);

        // streaming on lane 3
        in_valid = 1'b1; in_index = 3'd3; in_data = 32'h30;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stream_valid", out_valid, 8'b0000_1000);
            check("stream_data", out_data, 32'h30 + 32'(i));
            check("stream_ready", in_ready, 1'b1);
            in_data = 32'h30 + 32'(i) + 32'h1;
            step();
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", busy, 1'b0);

        // reversed mapping
        r_valid = 1'b1; r_index = 3'd1; r_data = 32'h77; r_out_ready = 8'h00;
        step();
        r_valid = 1'b0;
        check("rev_idx1", r_out_valid, 8'b0100_0000);
        check("rev_data", r_out_data, 32'h77);
        r_out_ready = 8'hFF;
        r_valid = 1'b1; r_index = 3'd7; r_data = 32'h78;
        step();
        r_valid = 1'b0;
        check("rev_idx7", r_out_valid, 8'b0000_0001);
        step();
        check("rev_empty", r_busy, 1'b0);

        // N=6 out-of-range discard
        s_valid = 1'b1; s_index = 3'd7; s_data = 32'h99; s_out_ready = 6'h3F;
        step();
        s_valid = 1'b0;
        check("n6_err_pulse", s_err, 1'b1);
        check("n6_err_valid", s_out_valid, 6'h00);
        check("n6_err_busy", s_busy, 1'b0);
        check("n6_err_ready", s_ready, 1'b1);
        step();
        check("n6_err_clear", s_err, 1'b0);
        s_valid = 1'b1; s_index = 3'd5; s_data = 32'h55;
        step();
        s_valid = 1'b0;
        check("n6_lane5", s_out_valid, 6'b10_0000);
        check("n6_lane5_err", s_err, 1'b0);
        step();

        // async reset while holding two entries
        out_ready = 8'h00;
        in_valid = 1'b1; in_index = 3'd4; in_data = 32'hC4;
        step();
        in_index = 3'd6; in_data = 32'hC6;
        step();
        in_valid = 1'b0;
        check("pre_rst_skid", in_ready, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", out_valid, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_data", out_data, 32'h0);
        check("arst_ready", in_ready, 1'b0);
        step();
        #2 reset = 1'b1;
        out_ready = 8'hFF;
        step();
        check("post_rst_valid", out_valid, 8'h00);
        check("post_rst_ready", in_ready, 1'b1);
        step();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_valid2", out_valid, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
